uart_sdram_loader: RTL and testbench

//   Boot/program loader between the UART byte stream and the SDRAM bridge port of soc_system.
//   - Consumes received bytes on the UART out-stream (rx_*) and parses framed write packets.
//   - Packs payload bytes into 32-bit words and issues single-word writes on the sdram_* port.
//   - Lets the host load programs into SDRAM before the stack CPU is released.

---
 rtl/uart_sdram_loader.sv | 214 +++++++++++++++++++++
 tb/tb_uart_sdram_loader.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sdram_loader.sv
// UART-to-SDRAM boot loader: parses framed write packets and issues single-word writes.
// Optional host echo (ACK/NAK byte after each frame) is enabled with `define UART_LOADER_ECHO_EN.
module uart_sdram_loader #(
    parameter int          ADDR_W         = 22,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_error,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [3:0]        sdram_byte_enable,
    output logic              sdram_write,
    output logic [31:0]       sdram_write_data,
    output logic              sdram_read,
    input  logic              sdram_acknowledge,
`ifdef UART_LOADER_ECHO_EN
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        hdr_cnt;
    logic [15:0]       hdr_lo;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       idle_cnt;
    logic              done_q;
    logic              error_q;
    logic              finish;
    logic              abort;
    logic              timeout_hit;
    logic              magic_seen;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == TIMEOUT_CYCLES - 1);
    assign magic_seen  = (state == S_IDLE) && rx_valid && !rx_error && (rx_data == MAGIC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (magic_seen) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_error) begin
                        abort = 1'b1;
                    end else if (hdr_cnt == 3'd4) begin
                        if ({rx_data, hdr_lo[7:0]} == 16'd0) begin
                            finish = 1'b1;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_error) begin
                        abort = 1'b1;
                    end else if (byte_idx == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            S_WRITE: begin
                if (sdram_acknowledge) begin
                    if (remaining == 16'd1) begin
                        finish = 1'b1;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
`ifdef UART_LOADER_ECHO_EN
            S_RESP: begin
                if (tx_ready) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
        if (finish || abort) begin
`ifdef UART_LOADER_ECHO_EN
            state_next = S_RESP;
`else
            state_next = S_IDLE;
`endif
        end
    end

    // Header bytes A0/A1 are buffered; the address register is loaded once A2 arrives,
    // truncating anything above ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt   <= 3'd0;
            hdr_lo    <= 16'd0;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            remaining <= 16'd0;
            cur_addr  <= '0;
            idle_cnt  <= 32'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (abort) begin
                error_q <= 1'b1;
            end else if (magic_seen) begin
                error_q <= 1'b0;
            end
            if ((state == S_HDR || state == S_DATA) && !rx_valid) begin
                idle_cnt <= idle_cnt + 32'd1;
            end else begin
                idle_cnt <= 32'd0;
            end
            unique case (state)
                S_IDLE: begin
                    hdr_cnt  <= 3'd0;
                    byte_idx <= 2'd0;
                end
                S_HDR: begin
                    if (rx_valid && !rx_error) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        unique case (hdr_cnt)
                            3'd0:    hdr_lo[7:0]  <= rx_data;
                            3'd1:    hdr_lo[15:8] <= rx_data;
                            3'd2:    cur_addr     <= ADDR_W'({rx_data, hdr_lo});
                            3'd3:    hdr_lo[7:0]  <= rx_data;
                            default: remaining    <= {rx_data, hdr_lo[7:0]};
                        endcase
                    end
                end
                S_DATA: begin
                    if (rx_valid && !rx_error) begin
                        word[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx                      <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (sdram_acknowledge) begin
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_LOADER_ECHO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data <= 8'h00;
        end else if (finish) begin
            tx_data <= 8'h06;
        end else if (abort) begin
            tx_data <= 8'h15;
        end
    end

    assign tx_valid = (state == S_RESP);
`endif

    assign sdram_write       = (state == S_WRITE);
    assign sdram_byte_enable = sdram_write ? 4'hF : 4'h0;
    assign sdram_read        = 1'b0;
    assign sdram_address     = cur_addr;
    assign sdram_write_data  = word;
    assign busy              = (state != S_IDLE);
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_uart_sdram_loader.sv
// Self-checking bench for uart_sdram_loader: random frames against a queue-based write model.
module tb_uart_sdram_loader;

    localparam int ADDR_W = 22;
    localparam int TMO    = 16;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_error;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] sdram_address;
    logic [3:0]        sdram_byte_enable;
    logic              sdram_write;
    logic [31:0]       sdram_write_data;
    logic              sdram_read;
    logic              sdram_acknowledge;
    logic              busy;
    logic              done;
    logic              error;
`ifdef UART_LOADER_ECHO_EN
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    assign tx_ready = 1'b1;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int exp_done = 0;
    int done_cnt = 0;
    int ack_delay = 0;
    bit ack_enable = 1'b1;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    uart_sdram_loader #(
        .ADDR_W(ADDR_W),
        .MAGIC(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_error(rx_error),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .sdram_address(sdram_address),
        .sdram_byte_enable(sdram_byte_enable),
        .sdram_write(sdram_write),
        .sdram_write_data(sdram_write_data),
        .sdram_read(sdram_read),
        .sdram_acknowledge(sdram_acknowledge),
`ifdef UART_LOADER_ECHO_EN
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
`endif
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Bridge model: acknowledges a held request after ack_delay cycles and logs the write.
    initial begin
        int wait_cnt;
        logic [ADDR_W-1:0] hold_addr;
        logic [31:0] hold_data;
        wait_cnt = 0;
        hold_addr = '0;
        hold_data = '0;
        sdram_acknowledge = 1'b0;
        forever begin
            @(negedge clk);
            sdram_acknowledge = 1'b0;
            if (sdram_write === 1'b1) begin
                if (wait_cnt == 0) begin
                    hold_addr = sdram_address;
                    hold_data = sdram_write_data;
                end else begin
                    n_cmp++;
                    if (sdram_address !== hold_addr || sdram_write_data !== hold_data) begin
                        n_fail++;
                        $display("[TB] FAIL write_stable: got %h/%h expected %h/%h",
                                 sdram_address, sdram_write_data, hold_addr, hold_data);
                    end
                end
                n_cmp++;
                if (sdram_byte_enable !== 4'hF || sdram_read !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL write_be: got be=%h rd=%b expected be=f rd=0",
                             sdram_byte_enable, sdram_read);
                end
                if (ack_enable && wait_cnt >= ack_delay) begin
                    sdram_acknowledge = 1'b1;
                    obs_addr.push_back(sdram_address);
                    obs_data.push_back(sdram_write_data);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (sdram_byte_enable !== 4'h0 || sdram_read !== 1'b0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL idle_be: got be=%h rd=%b expected 0/0",
                             sdram_byte_enable, sdram_read);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit err);
        int t;
        @(negedge clk);
        rx_data  = b;
        rx_error = err;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL rx_ready_wait: got ready=%b expected 1 within 200 cycles", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL busy_wait: got busy=%b expected 0 within 300 cycles", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    // Sends a complete frame and records the writes the frame rules imply.
    task automatic send_frame(input logic [23:0] a, input logic [15:0] len,
                              input logic [7:0] payload[$], input int gap_max);
        logic [7:0] bytes[$];
        int base;
        int full;
        logic [31:0] fv;
        bytes = {};
        bytes.push_back(8'hA5);
        bytes.push_back(a[7:0]);
        bytes.push_back(a[15:8]);
        bytes.push_back(a[23:16]);
        bytes.push_back(len[7:0]);
        bytes.push_back(len[15:8]);
        base = int'(a) % (1 << ADDR_W);
        for (int i = 0; i < int'(len); i++) begin
            full = (base + i) % (1 << ADDR_W);
            fv = full;
            exp_addr.push_back(fv[ADDR_W-1:0]);
            exp_data.push_back({payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]});
            for (int k = 0; k < 4; k++) bytes.push_back(payload[4*i+k]);
        end
        exp_done++;
        foreach (bytes[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(bytes[i], 1'b0);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_data = 8'h00;
        rx_error = 1'b0;
        rx_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rx_ready, sdram_write, busy, done, error, sdram_read} !== 6'b100000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 100000",
                     {rx_ready, sdram_write, busy, done, error, sdram_read});
        end
        n_cmp++;
        if (sdram_byte_enable !== 4'h0 || sdram_address !== '0 || sdram_write_data !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got be=%h a=%h d=%h expected 0/0/0",
                     sdram_byte_enable, sdram_address, sdram_write_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [7:0] p[$];
        p = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ack_delay = 3;
        send_frame(24'h000010, 16'd1, p, 0);
        n_cmp++;
        if (obs_addr.size() != 1 || obs_data.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL single_count: got %0d writes expected 1", obs_addr.size());
        end else begin
            n_cmp++;
            if (obs_addr[0] !== 22'h000010 || obs_data[0] !== 32'hDEADBEEF) begin
                n_fail++;
                $display("[TB] FAIL single_word: got %h/%h expected 000010/deadbeef",
                         obs_addr[0], obs_data[0]);
            end
        end
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_fail++;
            $display("[TB] FAIL single_done: got %0d expected %0d", done_cnt, exp_done);
        end
        exp_addr = {}; exp_data = {}; obs_addr = {}; obs_data = {};
    endtask

    task automatic test_wrap();
        logic [7:0] p[$];
        p = {};
        for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
        ack_delay = 2;
        send_frame(24'h3FFFFF, 16'd2, p, 0);
        n_cmp++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got %0d writes expected 2", obs_addr.size());
        end else begin
            n_cmp++;
            if (obs_addr[0] !== 22'h3FFFFF || obs_addr[1] !== 22'h000000
                || obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1]) begin
                n_fail++;
                $display("[TB] FAIL wrap_words: got %h:%h %h:%h expected 3fffff:%h 000000:%h",
                         obs_addr[0], obs_data[0], obs_addr[1], obs_data[1], exp_data[0], exp_data[1]);
            end
        end
        exp_addr = {}; exp_data = {}; obs_addr = {}; obs_data = {};
    endtask

    task automatic test_random_frames(input int n_frames, input int gap_max, input int max_delay);
        logic [7:0] p[$];
        int len;
        for (int f = 0; f < n_frames; f++) begin
            len = $urandom_range(0, 4);
            p = {};
            for (int i = 0; i < 4 * len; i++) p.push_back(8'($urandom));
            ack_delay = $urandom_range(0, max_delay);
            send_frame(24'($urandom), 16'(len), p, gap_max);
        end
        n_cmp++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("[TB] FAIL random_count: got %0d writes expected %0d", obs_addr.size(), exp_addr.size());
        end
        foreach (exp_addr[i]) begin
            if (i < obs_addr.size()) begin
                n_cmp++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("[TB] FAIL random_word%0d: got %h:%h expected %h:%h",
                             i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_fail++;
            $display("[TB] FAIL random_done: got %0d expected %0d", done_cnt, exp_done);
        end
        exp_addr = {}; exp_data = {}; obs_addr = {}; obs_data = {};
    endtask

    task automatic test_rx_error();
        logic [7:0] seq[$];
        int done_before;
        seq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        done_before = done_cnt;
        foreach (seq[i]) send_byte(seq[i], 1'b0);
        send_byte(8'h33, 1'b1);
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_abort: got error=%b busy=%b expected 1/0", error, busy);
        end
        send_byte(8'hA5, 1'b1);
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_idle_drop: got error=%b busy=%b expected 1/0", error, busy);
        end
        send_byte(8'hA5, 1'b0);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_clear: got error=%b busy=%b expected 0/1", error, busy);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
        wait_idle();
        exp_done++;
        send_byte(8'h5A, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_idle_noset: got error=%b busy=%b expected 0/0", error, busy);
        end
        n_cmp++;
        if (obs_addr.size() != 0 || done_cnt != done_before + 1) begin
            n_fail++;
            $display("[TB] FAIL err_nowrite: got writes=%0d dones=%0d expected 0/%0d",
                     obs_addr.size(), done_cnt - done_before, 1);
        end
        obs_addr = {}; obs_data = {};
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got error=%b busy=%b expected 0/1", error, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_fire: got error=%b busy=%b expected 1/0", error, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_junk();
        logic [7:0] seq[$];
        int done_before;
        seq = '{8'h00, 8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        done_before = done_cnt;
        foreach (seq[i]) send_byte(seq[i], 1'b0);
        wait_idle();
        exp_done++;
        n_cmp++;
        if (done_cnt != done_before + 1 || obs_addr.size() != 0 || error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL junk_frame: got dones=%0d writes=%0d error=%b expected 1/0/0",
                     done_cnt - done_before, obs_addr.size(), error);
        end
        obs_addr = {}; obs_data = {};
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] p[$];
        int t;
        ack_enable = 1'b0;
        p = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (p[i]) send_byte(p[i], 1'b0);
        t = 0;
        while (sdram_write !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (sdram_write !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rmw_request: got write=%b expected 1", sdram_write);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (sdram_write !== 1'b0 || busy !== 1'b0 || sdram_byte_enable !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL rmw_async: got write=%b busy=%b be=%h expected 0/0/0",
                     sdram_write, busy, sdram_byte_enable);
        end
        @(negedge clk);
        reset = 1'b0;
        ack_enable = 1'b1;
        obs_addr = {}; obs_data = {};
        p = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
        ack_delay = 1;
        send_frame(24'h123456, 16'd2, p, 0);
        n_cmp++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL rmw_count: got %0d writes expected 2", obs_addr.size());
        end else begin
            n_cmp++;
            if (obs_addr[0] !== 22'h123456 || obs_data[0] !== 32'h12345678
                || obs_addr[1] !== 22'h123457 || obs_data[1] !== 32'h9ABCDEF0) begin
                n_fail++;
                $display("[TB] FAIL rmw_words: got %h:%h %h:%h expected 123456:12345678 123457:9abcdef0",
                         obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
            end
        end
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_fail++;
            $display("[TB] FAIL rmw_done: got %0d expected %0d", done_cnt, exp_done);
        end
        exp_addr = {}; exp_data = {}; obs_addr = {}; obs_data = {};
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrap();
        test_random_frames(8, 12, 4);
        test_random_frames(4, 0, 0);
        test_rx_error();
        test_timeout();
        test_junk();
        test_reset_mid_write();
        test_random_frames(6, 6, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
